output_buffer: RTL and testbench

//  Transmit side of the NPU datapath: captures four lane results (A..D) from the compute core
//  on a one-cycle enable and serializes them as bytes over an 8-bit valid/ready link off-chip.

---
 rtl/output_buffer.sv | 136 +++++++++++++
 tb/tb_output_buffer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/output_buffer.sv
// Transmit-side output buffer: latches four lane results on a capture pulse and streams
// them off-chip as bytes over an 8-bit valid/ready link.
module output_buffer #(
    parameter int unsigned RES_W     = 16,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             CLKEXT,
    input  logic             CLR_BUF_OUT,
    input  logic             EN_BUF_OUT,
    input  logic [RES_W-1:0] RA,
    input  logic [RES_W-1:0] RB,
    input  logic [RES_W-1:0] RC,
    input  logic [RES_W-1:0] RD,
    output logic [7:0]       DOUT,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVR
);

    localparam int unsigned BPL     = RES_W / 8;
    localparam int unsigned NBYTES  = 4 * BPL;
    localparam int unsigned IDX_W   = $clog2(NBYTES);
    localparam int unsigned FRAME_W = 4 * RES_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic {
        StIdle,
        StSend
    } state_t;

    state_t             r_state;
    logic [FRAME_W-1:0] r_hold;
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_dout;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_ovr;

    logic [FRAME_W-1:0] w_frame_in;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [7:0]         w_first_byte;
    logic [7:0]         w_next_byte;
    logic               w_xfer;
    logic               w_last;

    // Lane A occupies the low bits so byte k lives in lane k/BPL.
    function automatic logic [7:0] f_byte(input logic [FRAME_W-1:0] frame,
                                          input logic [IDX_W-1:0]   idx);
        int unsigned        k;
        int unsigned        lane;
        int unsigned        pos;
        int unsigned        b;
        logic [FRAME_W-1:0] sh;
        k    = 32'(idx);
        lane = k / BPL;
        pos  = k % BPL;
        b    = lane * BPL + (MSB_FIRST ? (BPL - 1 - pos) : pos);
        sh   = frame >> (8 * b);
        return sh[7:0];
    endfunction

    assign w_frame_in   = {RD, RC, RB, RA};
    assign w_xfer       = r_valid & DOUT_READY;
    assign w_last       = (r_idx == LAST_IDX);
    assign w_idx_nxt    = r_idx + IDX_W'(1);
    assign w_first_byte = f_byte(w_frame_in, IDX_W'(0));
    assign w_next_byte  = f_byte(r_hold, w_idx_nxt);

    always_ff @(posedge CLKEXT or negedge CLR_BUF_OUT) begin
        if (!CLR_BUF_OUT) begin
            r_state <= StIdle;
            r_hold  <= '0;
            r_idx   <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (EN_BUF_OUT) begin
                        r_hold  <= w_frame_in;
                        r_idx   <= '0;
                        r_dout  <= w_first_byte;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= StSend;
                    end
                end
                StSend: begin
                    // Only the final-transfer edge may accept a new capture.
                    if (EN_BUF_OUT && !(w_xfer && w_last)) begin
                        r_ovr <= 1'b1;
                    end
                    if (w_xfer) begin
                        if (w_last) begin
                            r_done <= 1'b1;
                            if (EN_BUF_OUT) begin
                                r_hold <= w_frame_in;
                                r_idx  <= '0;
                                r_dout <= w_first_byte;
                            end else begin
                                r_idx   <= '0;
                                r_dout  <= '0;
                                r_valid <= 1'b0;
                                r_busy  <= 1'b0;
                                r_state <= StIdle;
                            end
                        end else begin
                            r_idx  <= w_idx_nxt;
                            r_dout <= w_next_byte;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_dout  <= '0;
                end
            endcase
        end
    end

    assign DOUT       = r_dout;
    assign DOUT_VALID = r_valid;
    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign OVR        = r_ovr;

endmodule

// File: tb/tb_output_buffer.sv
// Scoreboard bench for output_buffer: one LS-first and one MS-first instance share stimulus,
// each with its own expected-byte queue checked by a negedge monitor.
module tb_output_buffer;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        ready = 1'b0;
    logic [15:0] ra = '0;
    logic [15:0] rb = '0;
    logic [15:0] rc = '0;
    logic [15:0] rd = '0;

    logic [7:0]  dout [2];
    logic        valid [2];
    logic        busy [2];
    logic        done [2];
    logic        ovr [2];

    exp_t        q [2][$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt [2];
    bit          pend [2];

    always #5 clk = ~clk;

    output_buffer #(.RES_W(16), .MSB_FIRST(1'b0)) u_dut_ls (
        .CLKEXT(clk), .CLR_BUF_OUT(rst_n), .EN_BUF_OUT(en),
        .RA(ra), .RB(rb), .RC(rc), .RD(rd),
        .DOUT(dout[0]), .DOUT_VALID(valid[0]), .DOUT_READY(ready),
        .BUSY(busy[0]), .DONE(done[0]), .OVR(ovr[0])
    );

    output_buffer #(.RES_W(16), .MSB_FIRST(1'b1)) u_dut_ms (
        .CLKEXT(clk), .CLR_BUF_OUT(rst_n), .EN_BUF_OUT(en),
        .RA(ra), .RB(rb), .RC(rc), .RD(rd),
        .DOUT(dout[1]), .DOUT_VALID(valid[1]), .DOUT_READY(ready),
        .BUSY(busy[1]), .DONE(done[1]), .OVR(ovr[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input bit v, input bit b, input bit o);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_valid%0d", tag, d), 32'(valid[d]), 32'(v));
            chk($sformatf("%s_busy%0d", tag, d), 32'(busy[d]), 32'(b));
            chk($sformatf("%s_ovr%0d", tag, d), 32'(ovr[d]), 32'(o));
            if (!v) chk($sformatf("%s_dout%0d", tag, d), 32'(dout[d]), 32'(0));
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk_state(tag, 1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_done%0d", tag, d), 32'(done[d]), 32'(0));
        end
    endtask

    // Expected bytes are packed first-byte-in-MSBs.
    task automatic push_frame(input logic [63:0] v_ls, input logic [63:0] v_ms);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.last = (i == 7);
            e.b    = v_ls[63-8*i -: 8];
            q[0].push_back(e);
            e.b    = v_ms[63-8*i -: 8];
            q[1].push_back(e);
        end
    endtask

    task automatic start_frame(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                               input logic [15:0] d, input logic [63:0] v_ls,
                               input logic [63:0] v_ms);
        ra = a;
        rb = b;
        rc = c;
        rd = d;
        en = 1'b1;
        push_frame(v_ls, v_ms);
        tick();
        en = 1'b0;
    endtask

    task automatic wait_idle(input bit bp, input int limit, output int cycles);
        cycles = 0;
        while ((busy[0] || busy[1]) && cycles < limit) begin
            if (bp) ready = (cycles % 3 == 0);
            tick();
            cycles++;
        end
        ready = 1'b1;
        chk("idle_timeout", 32'(busy[0] | busy[1]), 32'(0));
    endtask

    task automatic chk_done_cnt(input string tag, input int exp);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_donecnt%0d", tag, d), 32'(done_cnt[d]), 32'(exp));
        end
    endtask

    // Monitor: a byte presented with READY high transfers on the coming edge.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                pend[d] = 1'b0;
            end else begin
                if (done[d]) done_cnt[d]++;
                if (done[d] || pend[d]) begin
                    chk($sformatf("done_pulse%0d", d), 32'(done[d]), 32'(pend[d]));
                end
                pend[d] = 1'b0;
                if (!valid[d]) begin
                    chk($sformatf("dout_idle%0d", d), 32'(dout[d]), 32'(0));
                end else if (q[d].size() == 0) begin
                    chk($sformatf("unexpected_valid%0d", d), 32'(valid[d]), 32'(0));
                end else begin
                    e = q[d][0];
                    chk($sformatf("dout%0d", d), 32'(dout[d]), 32'(e.b));
                    if (ready) begin
                        void'(q[d].pop_front());
                        pend[d] = e.last;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        done_cnt[0] = 0;
        done_cnt[1] = 0;

        // Test 1: reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ra    = 16'($urandom);
            rb    = 16'($urandom);
            rc    = 16'($urandom);
            rd    = 16'($urandom);
            en    = 1'($urandom);
            ready = 1'($urandom);
            #1;
            chk_reset_outs("t1_rst");
            tick();
        end
        en    = 1'b0;
        ready = 1'b0;
        rst_n = 1'b1;
        repeat (5) tick();
        chk_reset_outs("t1_idle");

        // Test 2: basic frame
        ready = 1'b1;
        start_frame(16'h1122, 16'h3344, 16'h5566, 16'h7788,
                    64'h2211443366558877, 64'h1122334455667788);
        chk_state("t2_start", 1'b1, 1'b1, 1'b0);
        wait_idle(1'b0, 50, cyc);
        chk("t2_cycles", 32'(cyc), 32'(8));
        repeat (2) tick();
        chk_state("t2_end", 1'b0, 1'b0, 1'b0);
        chk_done_cnt("t2", 1);

        // Test 3: backpressure 1,0,0
        start_frame(16'h1122, 16'h3344, 16'h5566, 16'h7788,
                    64'h2211443366558877, 64'h1122334455667788);
        wait_idle(1'b1, 100, cyc);
        chk("t3_cycles", 32'(cyc), 32'(22));
        repeat (2) tick();
        chk_state("t3_end", 1'b0, 1'b0, 1'b0);
        chk_done_cnt("t3", 2);

        // Test 4: back-to-back frames
        start_frame(16'h1122, 16'h3344, 16'h5566, 16'h7788,
                    64'h2211443366558877, 64'h1122334455667788);
        repeat (7) tick();
        start_frame(16'hAAAA, 16'hBBCC, 16'hDDEE, 16'hF0F1,
                    64'hAAAACCBBEEDDF1F0, 64'hAAAABBCCDDEEF0F1);
        chk_state("t4_b2b", 1'b1, 1'b1, 1'b0);
        wait_idle(1'b0, 50, cyc);
        chk("t4_cycles", 32'(cyc), 32'(8));
        repeat (2) tick();
        chk_state("t4_end", 1'b0, 1'b0, 1'b0);
        chk_done_cnt("t4", 4);

        // Test 5: overrun at byte index 3
        start_frame(16'h1122, 16'h3344, 16'h5566, 16'h7788,
                    64'h2211443366558877, 64'h1122334455667788);
        repeat (3) tick();
        ra = 16'h9999;
        rb = 16'h9999;
        rc = 16'h9999;
        rd = 16'h9999;
        en = 1'b1;
        tick();
        en = 1'b0;
        chk_state("t5_ovr", 1'b1, 1'b1, 1'b1);
        wait_idle(1'b0, 50, cyc);
        chk("t5_cycles", 32'(cyc), 32'(4));
        repeat (3) tick();
        chk_state("t5_end", 1'b0, 1'b0, 1'b1);
        chk_done_cnt("t5", 5);

        // Test 6: abort after byte 4, then a fresh frame
        start_frame(16'h1122, 16'h3344, 16'h5566, 16'h7788,
                    64'h2211443366558877, 64'h1122334455667788);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outs("t6_abort");
        q[0].delete();
        q[1].delete();
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk_reset_outs("t6_rel");
        chk_done_cnt("t6_abort", 5);
        start_frame(16'h1122, 16'h3344, 16'h5566, 16'h7788,
                    64'h2211443366558877, 64'h1122334455667788);
        chk_state("t6_start", 1'b1, 1'b1, 1'b0);
        wait_idle(1'b0, 50, cyc);
        chk("t6_cycles", 32'(cyc), 32'(8));
        repeat (2) tick();
        chk_state("t6_end", 1'b0, 1'b0, 1'b0);
        chk_done_cnt("t6", 6);

        chk("q_empty0", 32'(q[0].size()), 32'(0));
        chk("q_empty1", 32'(q[1].size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
